// File: rtl/sram_512x32_bank.sv
// rtl/sram_512x32_bank.sv - 512x32 single-port synchronous SRAM bank built from four byte slices

module sram_512x32_bank_slice #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Storage has no reset so contents survive reset and preloads stay intact.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

module sram_512x32_bank #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 wen,
  output logic [DATA_BITS-1:0] rdata
);

  logic       slice_we;
  logic       slice_re;
  logic [7:0] rdata_b0;
  logic [7:0] rdata_b1;
  logic [7:0] rdata_b2;
  logic [7:0] rdata_b3;

  // Writes are qualified with reset so nothing lands while it is held low.
  always_comb begin
    slice_we = en & wen & reset;
    slice_re = en & ~wen;
  end

  sram_512x32_bank_slice #(.ADDR_BITS(ADDR_BITS)) ram0 (
    .clk(clk), .rst_n(reset), .we(slice_we), .re(slice_re),
    .addr(addr), .wdata(wdata[7:0]), .rdata(rdata_b0)
  );

  sram_512x32_bank_slice #(.ADDR_BITS(ADDR_BITS)) ram1 (
    .clk(clk), .rst_n(reset), .we(slice_we), .re(slice_re),
    .addr(addr), .wdata(wdata[15:8]), .rdata(rdata_b1)
  );

  sram_512x32_bank_slice #(.ADDR_BITS(ADDR_BITS)) ram2 (
    .clk(clk), .rst_n(reset), .we(slice_we), .re(slice_re),
    .addr(addr), .wdata(wdata[23:16]), .rdata(rdata_b2)
  );

  sram_512x32_bank_slice #(.ADDR_BITS(ADDR_BITS)) ram3 (
    .clk(clk), .rst_n(reset), .we(slice_we), .re(slice_re),
    .addr(addr), .wdata(wdata[31:24]), .rdata(rdata_b3)
  );

  assign rdata = {rdata_b3, rdata_b2, rdata_b1, rdata_b0};

endmodule

// File: tb/tb_sram_512x32_bank.sv
// tb/tb_sram_512x32_bank.sv - scoreboard bench for sram_512x32_bank

module tb_sram_512x32_bank;

  logic        clk;
  logic        reset;
  logic        en;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q [$];

  sram_512x32_bank dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr),
    .wdata(wdata), .wen(wen), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {dut.ram3.mem[a], dut.ram2.mem[a], dut.ram1.mem[a], dut.ram0.mem[a]};
  endfunction

  // Drive on negedge; each returns at the following negedge.
  task automatic wr(input int a, input logic [31:0] d);
    en = 1'b1; wen = 1'b1; addr = 9'(a); wdata = d;
    @(negedge clk);
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] e);
    exp_q.push_back(e);
    en = 1'b1; wen = 1'b0; addr = 9'(a);
    @(negedge clk);
    en = 1'b0;
  endtask

  // Monitor: a read accepted at a rising edge is checked at the next falling edge.
  initial begin
    logic fire;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      fire = (reset === 1'b1) && (en === 1'b1) && (wen === 1'b0);
      @(negedge clk);
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_read", rdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("sb_read", rdata, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0; en = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    dut.ram0.mem[5] = 8'h78;
    dut.ram1.mem[5] = 8'h56;
    dut.ram2.mem[5] = 8'h34;
    dut.ram3.mem[5] = 8'h12;
    #1;
    check("reset_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_hold", rdata, 32'h0);
    reset = 1'b1;

    rd(5, 32'h12345678);

    wr(511, 32'hDEADBEEF);
    check("mem3_511", 32'(dut.ram3.mem[511]), 32'hDE);
    check("mem0_511", 32'(dut.ram0.mem[511]), 32'hEF);
    rd(511, 32'hDEADBEEF);

    rd(5, 32'h12345678);
    wr(0, 32'hCAFEF00D);
    check("write_hold", rdata, 32'h12345678);
    rd(0, 32'hCAFEF00D);

    wr(7, 32'hA5A55A5A);
    rd(7, 32'hA5A55A5A);

    rd(5, 32'h12345678);
    en = 1'b0; wen = 1'b1; wdata = 32'hFFFFFFFF; addr = 9'd5;
    repeat (10) @(negedge clk);
    wen = 1'b0;
    check("gate_rdata", rdata, 32'h12345678);
    check("gate_word5", word_at(5), 32'h12345678);
    rd(5, 32'h12345678);

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
    en = 1'b1; wen = 1'b1; addr = 9'd5; wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0; wen = 1'b0;
    check("reset_blocks_write", word_at(5), 32'h12345678);
    check("reset_rdata_held", rdata, 32'h0);
    #3;
    reset = 1'b1;
    @(negedge clk);
    rd(5, 32'h12345678);

    for (int a = 0; a < 512; a++) begin
      wr(a, 32'(a) * 32'h01010101);
    end
    for (int a = 0; a < 512; a++) begin
      rd(a, 32'(a) * 32'h01010101);
    end
    check("sweep_word0", word_at(0), 32'h0);
    check("sweep_word511", word_at(511), 32'd511 * 32'h01010101);

    @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
